// File: rtl/fpnew_pkg.sv
// Shared FPU types: status flags, format-arbiter payload and index-width helper.
package fpnew_pkg;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  localparam int unsigned NUM_FP_FORMATS    = 5;
  localparam int unsigned FMT_ARB_MAX_WIDTH = 64;

  function automatic int unsigned fmt_arb_idx_bits(int unsigned n);
    int unsigned bits;
    bits = 1;
    if (n > 1) bits = $clog2(n);
    return bits;
  endfunction

  localparam int unsigned FMT_ARB_IDX_BITS = fmt_arb_idx_bits(NUM_FP_FORMATS);

  // Result is stored at the widest supported width and narrowed at the consumer.
  typedef struct packed {
    logic [FMT_ARB_MAX_WIDTH-1:0] result;
    status_t                      status;
    logic                         ext_bit;
  } fmt_arb_payload_t;

endpackage

// File: rtl/fpnew_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr_i (mod N), one-hot plus index.
module fpnew_rr_picker
  import fpnew_pkg::*;
#(
  parameter int unsigned N    = 5,
  parameter int unsigned IdxW = fmt_arb_idx_bits(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            vld_o
);

  logic [IdxW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IdxW'((32'(ptr_i) + k) % N);
      if (!vld_o && req_i[cand]) begin
        vld_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/fpnew_opgroup_fmt_arbiter.sv
// Round-robin merge of per-format slice outputs into one registered valid/ready stage (1-cycle latency).
// FPNEW_FMT_ARB_SKID_EN adds a skid register so slice_ready_o has no path from out_ready_i; Width <= 64.
module fpnew_opgroup_fmt_arbiter
  import fpnew_pkg::*;
#(
  parameter int unsigned NumFormats = 5,
  parameter int unsigned Width      = 32,
  parameter type         TagType    = logic,
  localparam int unsigned FMT_BITS  = fmt_arb_idx_bits(NumFormats)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 flush_i,
  input  logic   [NumFormats-1:0][Width-1:0]   slice_result_i,
  input  status_t [NumFormats-1:0]             slice_status_i,
  input  logic   [NumFormats-1:0]              slice_ext_bit_i,
  input  TagType [NumFormats-1:0]              slice_tag_i,
  input  logic   [NumFormats-1:0]              slice_valid_i,
  output logic   [NumFormats-1:0]              slice_ready_o,
  input  logic   [NumFormats-1:0]              slice_busy_i,
  output logic   [Width-1:0]                   result_o,
  output status_t                              status_o,
  output logic                                 extension_bit_o,
  output TagType                               tag_o,
  output logic   [FMT_BITS-1:0]                fmt_o,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic                                 busy_o
);

  logic [NumFormats-1:0] grant;
  logic [FMT_BITS-1:0]   grant_idx;
  logic                  grant_vld;
  logic                  stage_ready;
  logic                  accept;
  logic                  skid_valid;

  logic [FMT_BITS-1:0] rr_q, rr_d;
  logic                out_valid_q, out_valid_d;
  fmt_arb_payload_t    out_pl_q, out_pl_d;
  TagType              out_tag_q, out_tag_d;
  logic [FMT_BITS-1:0] out_fmt_q, out_fmt_d;

  fmt_arb_payload_t new_pl;
  TagType           new_tag;

  fpnew_rr_picker #(
    .N    (NumFormats),
    .IdxW (FMT_BITS)
  ) i_picker (
    .req_i (slice_valid_i),
    .ptr_i (rr_q),
    .gnt_o (grant),
    .idx_o (grant_idx),
    .vld_o (grant_vld)
  );

  assign accept        = grant_vld & stage_ready & ~flush_i;
  assign slice_ready_o = grant & {NumFormats{stage_ready & ~flush_i}};

  always_comb begin
    new_pl         = '0;
    new_pl.result  = FMT_ARB_MAX_WIDTH'(slice_result_i[grant_idx]);
    new_pl.status  = slice_status_i[grant_idx];
    new_pl.ext_bit = slice_ext_bit_i[grant_idx];
    new_tag        = slice_tag_i[grant_idx];
  end

  // With a single format the pointer wraps to 0 on every accept, so it stays tied low.
  always_comb begin
    rr_d = rr_q;
    if (accept) begin
      rr_d = (grant_idx == FMT_BITS'(NumFormats - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

`ifdef FPNEW_FMT_ARB_SKID_EN
  logic                skid_valid_q, skid_valid_d;
  fmt_arb_payload_t    skid_pl_q, skid_pl_d;
  TagType              skid_tag_q, skid_tag_d;
  logic [FMT_BITS-1:0] skid_fmt_q, skid_fmt_d;

  assign stage_ready = ~skid_valid_q;
  assign skid_valid  = skid_valid_q;

  // The skid entry is always older than anything new, so it refills the output first.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_pl_d     = out_pl_q;
    out_tag_d    = out_tag_q;
    out_fmt_d    = out_fmt_q;
    skid_valid_d = skid_valid_q;
    skid_pl_d    = skid_pl_q;
    skid_tag_d   = skid_tag_q;
    skid_fmt_d   = skid_fmt_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready_i) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_pl_d     = skid_pl_q;
        out_tag_d    = skid_tag_q;
        out_fmt_d    = skid_fmt_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_pl_d    = new_pl;
        out_tag_d   = new_tag;
        out_fmt_d   = grant_idx;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_pl_d    = new_pl;
      skid_tag_d   = new_tag;
      skid_fmt_d   = grant_idx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      skid_valid_q <= 1'b0;
      skid_pl_q    <= '0;
      skid_tag_q   <= '0;
      skid_fmt_q   <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_pl_q    <= skid_pl_d;
      skid_tag_q   <= skid_tag_d;
      skid_fmt_q   <= skid_fmt_d;
    end
  end
`else
  assign stage_ready = ~out_valid_q | out_ready_i;
  assign skid_valid  = 1'b0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_pl_d    = out_pl_q;
    out_tag_d   = out_tag_q;
    out_fmt_d   = out_fmt_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_pl_d    = new_pl;
      out_tag_d   = new_tag;
      out_fmt_d   = grant_idx;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_pl_q    <= '0;
      out_tag_q   <= '0;
      out_fmt_q   <= '0;
    end else begin
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_pl_q    <= out_pl_d;
      out_tag_q   <= out_tag_d;
      out_fmt_q   <= out_fmt_d;
    end
  end

  assign result_o        = Width'(out_pl_q.result);
  assign status_o        = out_pl_q.status;
  assign extension_bit_o = out_pl_q.ext_bit;
  assign tag_o           = out_tag_q;
  assign fmt_o           = out_fmt_q;
  assign out_valid_o     = out_valid_q;
  assign busy_o          = out_valid_q | skid_valid | (|slice_busy_i);

endmodule

// File: tb/tb_fpnew_opgroup_fmt_arbiter.sv
// Bench for the format arbiter: vector table for arbitration order, hand sequences for stall/flush/reset.
module tb_fpnew_opgroup_fmt_arbiter;
  import fpnew_pkg::*;

  localparam int NF = 5;
  typedef logic [3:0] tag_t;

  logic                    clk_i = 1'b0;
  logic                    rst_i;
  logic                    flush_i;
  logic [NF-1:0][31:0]     slice_result_i;
  status_t [NF-1:0]        slice_status_i;
  logic [NF-1:0]           slice_ext_bit_i;
  tag_t [NF-1:0]           slice_tag_i;
  logic [NF-1:0]           slice_valid_i;
  logic [NF-1:0]           slice_ready_o;
  logic [NF-1:0]           slice_busy_i;
  logic [31:0]             result_o;
  status_t                 status_o;
  logic                    extension_bit_o;
  tag_t                    tag_o;
  logic [2:0]              fmt_o;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic                    busy_o;

  fpnew_opgroup_fmt_arbiter #(
    .NumFormats (NF),
    .Width      (32),
    .TagType    (tag_t)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .flush_i         (flush_i),
    .slice_result_i  (slice_result_i),
    .slice_status_i  (slice_status_i),
    .slice_ext_bit_i (slice_ext_bit_i),
    .slice_tag_i     (slice_tag_i),
    .slice_valid_i   (slice_valid_i),
    .slice_ready_o   (slice_ready_o),
    .slice_busy_i    (slice_busy_i),
    .result_o        (result_o),
    .status_o        (status_o),
    .extension_bit_o (extension_bit_o),
    .tag_o           (tag_o),
    .fmt_o           (fmt_o),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0]  fmt;
    logic [31:0] res;
    status_t     st;
    logic        ext;
    tag_t        tag;
  } exp_t;

  typedef struct {
    logic [4:0] vld;
    logic       ordy;
    logic       fl;
    logic [4:0] exp_rdy;
    logic       exp_ov;
    logic [2:0] exp_fmt;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[14];
  int   checks = 0;
  int   errors = 0;
  int   rr_m   = 0;
  logic [31:0] exp_res0, exp_res2;

  function automatic int pick(input int ptr, input logic [4:0] v);
    for (int k = 0; k < NF; k++) begin
      if (v[(ptr + k) % NF]) return (ptr + k) % NF;
    end
    return 0;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic rand_payload();
    for (int i = 0; i < NF; i++) begin
      slice_result_i[i]  = $urandom;
      slice_status_i[i]  = status_t'(5'($urandom_range(0, 31)));
      slice_ext_bit_i[i] = 1'($urandom_range(0, 1));
      slice_tag_i[i]     = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic drive(input logic [4:0] v, input logic ordy, input logic fl);
    rand_payload();
    slice_valid_i = v;
    out_ready_i   = ordy;
    flush_i       = fl;
  endtask

  // Scoreboard: accepted slice payloads are queued; every output handshake pops and compares.
  always @(negedge clk_i) begin
    exp_t e;
    int   g;
    if (rst_i) begin
      sb_q.delete();
      rr_m = 0;
    end else begin
      if (out_valid_o && out_ready_i) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_output fmt %0d result %0h with nothing queued", fmt_o, result_o);
        end else begin
          e = sb_q.pop_front();
          check("sb_fmt", 32'(fmt_o), 32'(e.fmt));
          check("sb_result", result_o, e.res);
          check("sb_meta", 32'({status_o, extension_bit_o, tag_o}), 32'({e.st, e.ext, e.tag}));
        end
      end
      if (flush_i) begin
        check("flush_no_ready", 32'(slice_ready_o), 32'(0));
        sb_q.delete();
      end else if (|(slice_valid_i & slice_ready_o)) begin
        g = pick(rr_m, slice_valid_i);
        check("grant_onehot", 32'(slice_valid_i & slice_ready_o), 32'(1) << g);
        e.fmt = 3'(g);
        e.res = slice_result_i[g];
        e.st  = slice_status_i[g];
        e.ext = slice_ext_bit_i[g];
        e.tag = slice_tag_i[g];
        sb_q.push_back(e);
        rr_m = (g + 1) % NF;
      end
    end
  end

  task automatic step_check_ready(input string name, input logic [4:0] exp_rdy);
    @(negedge clk_i);
    check(name, 32'(slice_ready_o), 32'(exp_rdy));
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    //            vld       ordy  fl    exp_rdy   ov    fmt
    tbl[0]  = '{5'b11111, 1'b1, 1'b0, 5'b00001, 1'b1, 3'd0};
    tbl[1]  = '{5'b11111, 1'b1, 1'b0, 5'b00010, 1'b1, 3'd1};
    tbl[2]  = '{5'b11111, 1'b1, 1'b0, 5'b00100, 1'b1, 3'd2};
    tbl[3]  = '{5'b11111, 1'b1, 1'b0, 5'b01000, 1'b1, 3'd3};
    tbl[4]  = '{5'b11111, 1'b1, 1'b0, 5'b10000, 1'b1, 3'd4};
    tbl[5]  = '{5'b11111, 1'b1, 1'b0, 5'b00001, 1'b1, 3'd0};
    tbl[6]  = '{5'b00000, 1'b1, 1'b0, 5'b00000, 1'b0, 3'd0};
    tbl[7]  = '{5'b01000, 1'b1, 1'b0, 5'b01000, 1'b1, 3'd3};
    tbl[8]  = '{5'b00100, 1'b1, 1'b0, 5'b00100, 1'b1, 3'd2};
    tbl[9]  = '{5'b00010, 1'b1, 1'b0, 5'b00010, 1'b1, 3'd1};
    tbl[10] = '{5'b00011, 1'b1, 1'b0, 5'b00001, 1'b1, 3'd0};
    tbl[11] = '{5'b10001, 1'b1, 1'b0, 5'b10000, 1'b1, 3'd4};
    tbl[12] = '{5'b11111, 1'b1, 1'b1, 5'b00000, 1'b0, 3'd0};
    tbl[13] = '{5'b11111, 1'b1, 1'b0, 5'b00001, 1'b1, 3'd0};

    rst_i        = 1'b1;
    slice_busy_i = 5'b00100;
    drive(5'b00000, 1'b0, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_out_valid", 32'(out_valid_o), 32'(0));
    check("rst_result", result_o, 32'(0));
    check("rst_meta", 32'({status_o, extension_bit_o, tag_o, fmt_o}), 32'(0));
    check("rst_slice_ready", 32'(slice_ready_o), 32'(0));
    check("rst_busy_slice", 32'(busy_o), 32'(1));
    slice_busy_i = 5'b00000;
    #1;
    check("rst_busy_idle", 32'(busy_o), 32'(0));
    rst_i = 1'b0;

    for (int k = 0; k < 14; k++) begin
      drive(tbl[k].vld, tbl[k].ordy, tbl[k].fl);
      step_check_ready($sformatf("tbl%0d_ready", k), tbl[k].exp_rdy);
      check($sformatf("tbl%0d_out_valid", k), 32'(out_valid_o), 32'(tbl[k].exp_ov));
      if (tbl[k].exp_ov) check($sformatf("tbl%0d_fmt", k), 32'(fmt_o), 32'(tbl[k].exp_fmt));
    end

    // Backpressure from a fresh pointer: slices 0 and 2 valid, output stalled for 4 cycles.
    rst_i = 1'b1;
    drive(5'b00000, 1'b0, 1'b0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    drive(5'b00101, 1'b0, 1'b0);
    exp_res0 = slice_result_i[0];
    step_check_ready("bp_ready_a", 5'b00001);
    check("bp_valid_a", 32'(out_valid_o), 32'(1));
    check("bp_result_a", result_o, exp_res0);
    for (int c = 1; c < 4; c++) begin
      drive(5'b00101, 1'b0, 1'b0);
`ifdef FPNEW_FMT_ARB_SKID_EN
      if (c == 1) exp_res2 = slice_result_i[2];
      step_check_ready($sformatf("bp_ready_%0d", c), (c == 1) ? 5'b00100 : 5'b00000);
`else
      step_check_ready($sformatf("bp_ready_%0d", c), 5'b00000);
`endif
      check($sformatf("bp_hold_fmt_%0d", c), 32'(fmt_o), 32'(0));
      check($sformatf("bp_hold_res_%0d", c), result_o, exp_res0);
    end
    check("bp_busy", 32'(busy_o), 32'(1));
    drive(5'b00100, 1'b1, 1'b0);
`ifdef FPNEW_FMT_ARB_SKID_EN
    step_check_ready("bp_release_ready", 5'b00000);
`else
    exp_res2 = slice_result_i[2];
    step_check_ready("bp_release_ready", 5'b00100);
`endif
    check("bp_second_valid", 32'(out_valid_o), 32'(1));
    check("bp_second_fmt", 32'(fmt_o), 32'(2));
    check("bp_second_res", result_o, exp_res2);
    drive(5'b00000, 1'b1, 1'b0);
    step_check_ready("bp_drain_ready", 5'b00000);
    check("bp_drained", 32'(out_valid_o), 32'(0));

    // Flush with a full output and pending requests; pointer is 3 here.
    drive(5'b00001, 1'b0, 1'b0);
    step_check_ready("fl_fill_ready", 5'b00001);
    check("fl_full", 32'(out_valid_o), 32'(1));
    drive(5'b00110, 1'b0, 1'b1);
    step_check_ready("fl_ready", 5'b00000);
    check("fl_cleared", 32'(out_valid_o), 32'(0));
    drive(5'b00110, 1'b1, 1'b0);
    step_check_ready("fl_rr_kept", 5'b00010);
    check("fl_next_fmt", 32'(fmt_o), 32'(1));
    drive(5'b00000, 1'b1, 1'b0);
    step_check_ready("fl_drain", 5'b00000);

    // Reset while stalled with buffered results: nothing may reappear afterwards.
    for (int c = 0; c < 2; c++) begin
      drive(5'b00011, 1'b0, 1'b0);
      @(posedge clk_i);
      #1;
    end
    check("rs_stalled_valid", 32'(out_valid_o), 32'(1));
    rst_i = 1'b1;
    drive(5'b00000, 1'b0, 1'b0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check("rs_valid_cleared", 32'(out_valid_o), 32'(0));
    check("rs_busy_cleared", 32'(busy_o), 32'(0));
    for (int c = 0; c < 3; c++) begin
      drive(5'b00000, 1'b1, 1'b0);
      @(posedge clk_i);
      #1;
      check($sformatf("rs_no_stale_%0d", c), 32'(out_valid_o), 32'(0));
    end
    drive(5'b11111, 1'b1, 1'b0);
    step_check_ready("rs_rr_zero", 5'b00001);
    check("rs_fmt", 32'(fmt_o), 32'(0));
    drive(5'b00000, 1'b1, 1'b0);
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    check("sb_empty", 32'(sb_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
